// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/writeback
// over a shared ALU, memory port and immediate extender, stalling on MemReady.
module multicycle_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       IllegalOp,
    output logic       InstrDone,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_BEQ      = 4'd9
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] state_q, state_d;

    logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;
    logic       illegal_c, done_c;

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic op5,
                                           input logic f75);
        case (f3)
            3'b000:  return (op5 && f75) ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    // Moore decode from state_q; only FETCH, MEMWRITE and BEQ look at live inputs.
    always_comb begin
        pc_write_c  = 1'b0;
        AdrSrc      = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        illegal_c   = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_c = MemReady;
                pc_write_c = MemReady;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b01;
                illegal_c = !(op == OP_LW || op == OP_SW || op == OP_RTYP ||
                              op == OP_IALU || op == OP_BEQ);
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                done_c      = MemReady;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, op[5], funct7_5);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct3, op[5], funct7_5);
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pc_write_c = Zero;
                done_c     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Architectural strobes are blocked while reset is held so an aborted access writes nothing.
    assign PCWrite   = pc_write_c  & rst_n;
    assign MemWrite  = mem_write_c & rst_n;
    assign IRWrite   = ir_write_c  & rst_n;
    assign RegWrite  = reg_write_c & rst_n;
    assign IllegalOp = illegal_c   & rst_n;
    assign InstrDone = done_c      & rst_n;
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by cycle
// and compares State plus the packed control outputs against hand-written vectors.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       IllegalOp, InstrDone;
    logic [3:0] State;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .IllegalOp(IllegalOp),
        .InstrDone(InstrDone), .State(State)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] ctl_vec;
    assign ctl_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, ALUControl, ImmSrc, IllegalOp, InstrDone};

    function automatic logic [17:0] ctl(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw,
                                        input logic [1:0] rs, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic [2:0] alu,
                                        input logic [1:0] imm, input logic ill,
                                        input logic done);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill, done};
    endfunction

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check the current cycle (inputs already applied), then advance to the next negedge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] c);
        #1;
        check_eq({tag, ".state"}, {14'd0, State}, {14'd0, st});
        check_eq({tag, ".ctl"}, ctl_vec, c);
        @(negedge clk);
    endtask

    // Common expected vectors, parameterised by ImmSrc.
    function automatic logic [17:0] v_fetch(input logic mr, input logic [1:0] imm);
        return ctl(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
    endfunction
    function automatic logic [17:0] v_decode(input logic [1:0] imm, input logic ill);
        return ctl(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill, 0);
    endfunction
    function automatic logic [17:0] v_aluwb();
        return ctl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1);
    endfunction

    // driver tasks
    task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [1:0] sb, input logic [2:0] alu);
        op = o; funct3 = f3; funct7_5 = f7; MemReady = 1'b1;
        cyc({tag, ".fetch"},  4'd0, v_fetch(1, 2'b00));
        cyc({tag, ".decode"}, 4'd1, v_decode(2'b00, 0));
        cyc({tag, ".exec"},   (sb == 2'b00) ? 4'd6 : 4'd8,
            ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, alu, 2'b00, 0, 0));
        cyc({tag, ".aluwb"},  4'd7, v_aluwb());
    endtask

    task automatic run_beq(input string tag, input logic z);
        op = 7'b1100011; funct3 = 3'b000; funct7_5 = 1'b0; Zero = z; MemReady = 1'b1;
        cyc({tag, ".fetch"},  4'd0, v_fetch(1, 2'b10));
        cyc({tag, ".decode"}, 4'd1, v_decode(2'b10, 0));
        cyc({tag, ".beq"},    4'd9, ctl(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1));
    endtask

    initial begin
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7_5 = 1'b0;
        Zero = 1'b0; MemReady = 1'b1;
        #2;
        // Reset with MemReady high: FETCH selects but no IR/PC write.
        check_eq("rst.state", {14'd0, State}, 18'd0);
        check_eq("rst.ctl", ctl_vec, v_fetch(0, 2'b00));
        @(negedge clk);
        rst_n = 1'b1;

        // lw, MemReady tied high: 5 cycles
        op = 7'b0000011;
        cyc("lw.fetch",   4'd0, v_fetch(1, 2'b00));
        cyc("lw.decode",  4'd1, v_decode(2'b00, 0));
        cyc("lw.memadr",  4'd2, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
        cyc("lw.memread", 4'd3, ctl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        cyc("lw.memwb",   4'd4, ctl(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1));

        // sw with two wait cycles in MEMWRITE: 6 cycles
        op = 7'b0100011;
        cyc("sw.fetch",  4'd0, v_fetch(1, 2'b01));
        cyc("sw.decode", 4'd1, v_decode(2'b01, 0));
        cyc("sw.memadr", 4'd2, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
        MemReady = 1'b0;
        cyc("sw.wait0", 4'd5, ctl(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
        cyc("sw.wait1", 4'd5, ctl(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
        MemReady = 1'b1;
        cyc("sw.done",  4'd5, ctl(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 1));

        // sw aborted by reset in MEMWRITE
        cyc("swr.fetch",  4'd0, v_fetch(1, 2'b01));
        cyc("swr.decode", 4'd1, v_decode(2'b01, 0));
        cyc("swr.memadr", 4'd2, ctl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
        MemReady = 1'b0;
        #2;
        check_eq("swr.pre.state", {14'd0, State}, 18'd5);
        rst_n = 1'b0;
        #1;
        check_eq("swr.rst.state", {14'd0, State}, 18'd0);
        check_eq("swr.rst.ctl", ctl_vec, v_fetch(0, 2'b01));
        MemReady = 1'b1;
        #1;
        check_eq("swr.rst.mr.ctl", ctl_vec, v_fetch(0, 2'b01));
        @(negedge clk);
        rst_n = 1'b1; MemReady = 1'b0;
        // A FETCH wait cycle, then a normal fetch
        cyc("post.fetchwait", 4'd0, v_fetch(0, 2'b01));
        cyc("post.fetchwait2", 4'd0, v_fetch(0, 2'b01));
        op = 7'b0110011; MemReady = 1'b1;

        // funct decode through EXECR / EXECI
        run_alu("rsub", 7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
        run_alu("addi", 7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000);
        run_alu("ror",  7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011);
        run_alu("rslt", 7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101);
        run_alu("iand", 7'b0010011, 3'b111, 1'b0, 2'b01, 3'b010);
        run_alu("rsll", 7'b0110011, 3'b001, 1'b1, 2'b00, 3'b000);

        // beq taken and not taken
        run_beq("beq_t", 1'b1);
        run_beq("beq_nt", 1'b0);

        // jal: unsupported, two cycles then back to FETCH
        op = 7'b1101111;
        cyc("jal.fetch",  4'd0, v_fetch(1, 2'b00));
        cyc("jal.decode", 4'd1, v_decode(2'b00, 1));
        cyc("jal.next",   4'd0, v_fetch(1, 2'b00));
        cyc("jal.decode2", 4'd1, v_decode(2'b00, 1));

        // illegal state code recovers to FETCH
        force dut.state_q = 4'd12;
        #1;
        release dut.state_q;
        #1;
        check_eq("ill12.state", {14'd0, State}, 18'd12);
        check_eq("ill12.ctl", ctl_vec, ctl(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
        @(negedge clk);
        cyc("ill12.recover", 4'd0, v_fetch(1, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle main controller for the RV32I core. It sequences a shared datapath through fetch, decode, execute, memory and writeback over several clock cycles. A single ALU, a single memory port and the immediate extender are reused across those cycles. It drives the extender's `ImmSrc` select, the ALU operation, the operand and result multiplexers, and all architectural write strobes. It also stalls on a memory-ready handshake.

## Interface
Parameters:
- `RESET_STATE`, default 4'd0 (FETCH): state entered on reset.

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 7: instr[6:0] from the instruction register.
- `funct3` input 3: instr[14:12].
- `funct7_5` input 1: instr[30].
- `Zero` input 1: ALU zero flag.
- `MemReady` input 1: shared memory completed the current access this cycle.
- `PCWrite` output 1: load the PC from the result bus.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = result bus.
- `MemWrite` output 1: data store strobe.
- `IRWrite` output 1: load the instruction register and OldPC.
- `RegWrite` output 1: register file write.
- `ResultSrc` output 2: result bus select; 00 = ALUOut, 01 = read data, 10 = ALUResult.
- `ALUSrcA` output 2: ALU operand A select; 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB` output 2: ALU operand B select; 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ALUControl` output 3: ALU operation; 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `ImmSrc` output 2: extender select; 00 = I-type, 01 = S-type, 10 = B-type. The controller never drives 11.
- `IllegalOp` output 1: one-cycle pulse when an unsupported opcode is decoded.
- `InstrDone` output 1: one-cycle pulse in the final cycle of each instruction.
- `State` output 4: current state, for debug.

## Operation
- The state machine is Moore style: outputs decode from the 4-bit state register only, except where a gate on `MemReady`, `Zero` or `op` is noted.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, BEQ=9. Codes 10–15 are illegal and go to FETCH on the next edge.
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
- Transitions:
  - FETCH → DECODE when `MemReady`=1; otherwise FETCH holds.
  - DECODE: lw or sw → MEMADR; R-type → EXECR; I-ALU → EXECI; beq → BEQ; any other opcode → FETCH with `IllegalOp`=1.
  - MEMADR: lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD → MEMWB when `MemReady`=1; otherwise it holds.
  - MEMWRITE → FETCH when `MemReady`=1; otherwise it holds.
  - EXECR and EXECI → ALUWB.
  - MEMWB, ALUWB and BEQ → FETCH.
- Per-state outputs (anything not listed is 0):
  - FETCH: `ALUSrcA`=00, `ALUSrcB`=10, `ALUControl`=add, `ResultSrc`=10. `IRWrite` and `PCWrite` are asserted only when `MemReady`=1.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, add. This precomputes the branch target into ALUOut.
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, add.
  - MEMREAD: `AdrSrc`=1, `ResultSrc`=00.
  - MEMWRITE: `AdrSrc`=1, `ResultSrc`=00, `MemWrite`=1 (held until `MemReady`).
  - MEMWB: `ResultSrc`=01, `RegWrite`=1.
  - EXECR: `ALUSrcA`=10, `ALUSrcB`=00, funct-decoded.
  - EXECI: `ALUSrcA`=10, `ALUSrcB`=01, funct-decoded.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1.
  - BEQ: `ALUSrcA`=10, `ALUSrcB`=00, sub, `ResultSrc`=00, `PCWrite`=`Zero`.
- `ImmSrc` is combinational from `op` in every state: sw → 01, beq → 10, all others → 00.
- Funct decode (EXECR and EXECI), selected by `funct3`:
  - 000: sub when `op[5]` and `funct7_5` are both 1, otherwise add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other value: add.
- `InstrDone` is asserted in MEMWB, ALUWB, BEQ, and in MEMWRITE when `MemReady`=1.

## Timing
- Reset (`rst_n` low, at any time including mid-instruction):
  - The state becomes FETCH immediately.
  - `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `IllegalOp` and `InstrDone` are forced to 0 combinationally while `rst_n`=0.
  - The other outputs take their FETCH values.
  - An aborted instruction leaves no architectural write.
- Instruction latency with `MemReady` tied to 1:
  - lw: 5 cycles
  - sw, R-type, I-ALU: 4 cycles
  - beq: 3 cycles
  - Each wait cycle in FETCH, MEMREAD or MEMWRITE adds 1.
- The PC updates once per fetch, at the edge where FETCH sees `MemReady`=1. A taken beq updates the PC again at the end of BEQ.
- Illegal opcode: 2 cycles (FETCH, DECODE), then the next fetch. The PC has already advanced by 4.
- `MemReady` arriving in the same cycle that a state is entered completes that state in one cycle.

## Test plan
- Reset mid-MEMWRITE with `MemReady`=0: `State`=0 and `MemWrite`=0 immediately. After release, FETCH `ALUSrcB`=10 and `ResultSrc`=10.
- lw (op 0000011), `MemReady`=1: `State` goes 0,1,2,3,4,0. `ImmSrc`=00. `RegWrite` and `InstrDone` pulse only in cycle 5 with `ResultSrc`=01.
- sw (op 0100011), `MemReady` low for 2 cycles in MEMWRITE: `ImmSrc`=01, `MemWrite` high for 3 cycles, `InstrDone` in the last of them, total 6 cycles.
- R-type sub (`funct3`=000, `funct7_5`=1) → `ALUControl`=001. The same with op 0010011 (addi) → 000. `funct3`=110 → 011.
- beq with `Zero`=1: `ImmSrc`=10, BEQ asserts `PCWrite`=1 and `ALUControl`=001. With `Zero`=0, `PCWrite` stays 0 and the FSM still returns to FETCH.
- op 1101111 (jal, unsupported): `IllegalOp` pulses in DECODE, no `RegWrite`, next state FETCH. Forcing the state register to 12 returns the FSM to 0 on the next edge.
